prio_enc_queue: RTL and testbench
=================================

# prio_enc_queue

Parametrised, registered N-to-log2(N) priority encoder with request capture and a valid/ready output handshake. Single-cycle request pulses on any of N lines are latched into a pending register, and the highest-priority pending line is presented as a binary code. The line is cleared only when the consumer accepts it. The block sits between interrupt/event sources and a downstream handler that can service one event per cycle at most.

## Interface
Parameters:
- `N`, default 8: number of request lines; must be ≥ 2.
- `W`, default `$clog2(N)`: code width. Callers do not override it.

Ports:
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req`  input  N  request pulses; bit i set means event on line i.
- `out_ready`  input  1  consumer accepts `out_code` this cycle.
- `clr_ovf`  input  1  clears the `ovf` flag.
- `out_valid`  output  1  at least one line is pending.
- `out_code`  output  W  index of the selected pending line.
- `pending`  output  N  pending-request register, visible to software.
- `ovf`  output  1  sticky flag: a request arrived on a line that was already pending.

## Operation
- **State:**
  - `pend[N-1:0]`
  - `ovf`
  - `ptr[W-1:0]`, present only when `PRIO_ENC_RR_EN` is defined.
- **Reset values:**
  - `pend` = 0, so `pending` = 0, `out_valid` = 0 and `out_code` = 0.
  - `ovf` = 0.
  - `ptr` = N-1.
- **Selection:**
  - `out_valid` = |`pend`.
  - `out_code` is derived combinationally from `pend`. It is the selected index, or 0 when `pend` = 0.
- **Fixed mode:** the highest index wins. This is the 4-line truth table generalised to N: line 3 gives code 11 and line 0 gives code 00.
- **Pop:** occurs when `out_valid` && `out_ready`. It clears `pend[out_code]` at the next edge.
- **Capture:** `pend_next` = (`pend` & ~`pop_mask`) | `req`. A request on the line being popped in the same cycle stays pending. The new event is kept and is not an overflow.
- **Overflow:** `ovf` is set at the edge when any `req[i]` && `pend[i]` && !(`pop` && `out_code` == i).
  - `clr_ovf` clears `ovf`.
  - If a set and a clear occur in the same cycle, the set wins.
- `out_ready` has no effect while `out_valid` = 0.
- Requests on multiple lines in one cycle are all captured.
- Reset asserted mid-operation clears all state immediately, without waiting for `clk`. Pending events are lost.

## Timing
- Request-to-valid latency is 1 cycle. `req[i]` sampled at edge t makes `out_valid` = 1 after edge t.
- Pop takes effect at the edge where `out_valid` && `out_ready`. The next selection is visible immediately after that edge.
- Throughput is 1 pop per cycle while `out_ready` is held high.
- `out_code` is stable while `out_valid` = 1 and `out_ready` = 0, unless a higher-priority request arrives. In that case `out_code` may change at the next edge. The consumer must sample it in the same cycle it asserts `out_ready`.
- `ovf` changes only on clock edges, or asynchronously on reset.

## Configuration
- **`PRIO_ENC_RR_EN` defined:** round-robin priority.
  - The search descends from `ptr` with wrap-around: `ptr`, `ptr`-1, …, 0, N-1, … `ptr`+1.
  - On each pop of line k, `ptr` ← (k == 0) ? N-1 : k-1.
  - `ptr` is unchanged when there is no pop.
  - When N is not a power of two, `ptr` takes only the values 0..N-1.
- **`PRIO_ENC_RR_EN` undefined:** fixed highest-index priority. The `ptr` register is not instantiated. The port list is identical in both builds.

## Test plan
- **Reset and 4-line truth table:** N=4, fixed mode. Pulse `req` = 0001, then 0010, then 0100, then 1000, with `out_ready` = 1. Required `out_code` is 00, 01, 10, 11, with `out_valid` high exactly 1 cycle after each pulse. Asserting `rst_n` = 0 mid-sequence clears all outputs immediately.
- **Simultaneous capture, fixed mode:** N=8, single pulse `req` = 8'b1010_0110, then `out_ready` = 1. Required `out_code` sequence is 7, 5, 2, 1. `out_valid` drops after the 4th pop. `pending` steps through A6 → 26 → 06 → 02 → 00 (hex).
- **Backpressure and overflow:** pulse `req[3]`, hold `out_ready` = 0, pulse `req[3]` again. Required: `ovf` = 1 after that edge, and `pending` = 0x08. Asserting `clr_ovf` gives `ovf` = 0. `req[3]` coinciding with a pop of line 3 leaves `pending[3]` = 1 and `ovf` = 0.
- **Preemption:** line 2 pending and `out_ready` = 0, then pulse `req[6]`. Required: `out_code` changes from 2 to 6 after the edge. Pop order is 6, then 2.
- **Round-robin (`PRIO_ENC_RR_EN`):** N=4. Hold `req` = 1111 every cycle with `out_ready` = 1. Required `out_code` sequence is 3, 2, 1, 0, 3, 2, … with no line starved, and `ovf` is set on the second cycle.

Source files
------------

// File: rtl/prio_enc_queue.sv
// Registered N-to-log2(N) priority encoder with sticky request capture and a valid/ready pop.
// Define PRIO_ENC_RR_EN for round-robin priority; the default build uses fixed highest-index priority.
module prio_enc_queue #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    input  logic         clr_ovf,
    output logic         out_valid,
    output logic [W-1:0] out_code,
    output logic [N-1:0] pending,
    output logic         ovf
);
    // Handshake: a pop happens on a rising edge where out_valid && out_ready are both high;
    // out_ready is ignored while out_valid is low, and out_code must be taken in that same cycle.
    logic [N-1:0] pend;
    logic [N-1:0] pop_mask;
    logic [N-1:0] pend_next;
    logic [W-1:0] code;
    logic         pop;
    logic         ovf_set;

`ifdef PRIO_ENC_RR_EN
    logic [W-1:0] ptr;

    // Walk the search order backwards so the line nearest ptr is written last and wins.
    always_comb begin
        int idx;
        idx  = 0;
        code = '0;
        for (int d = N - 1; d >= 0; d--) begin
            idx = int'(ptr) - d;
            if (idx < 0) idx = idx + N;
            if (pend[idx]) code = W'(idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= W'(N - 1);
        end else if (pop) begin
            ptr <= (code == '0) ? W'(N - 1) : code - 1'b1;
        end
    end
`else
    always_comb begin
        code = '0;
        for (int i = 0; i < N; i++) begin
            if (pend[i]) code = W'(i);
        end
    end
`endif

    assign out_valid = |pend;
    assign out_code  = code;
    assign pending   = pend;
    assign pop       = out_valid && out_ready;
    assign pop_mask  = pop ? (N'(1) << code) : '0;
    // A request landing on the line being popped is a fresh event, not an overflow.
    assign ovf_set   = |(req & pend & ~pop_mask);
    assign pend_next = (pend & ~pop_mask) | req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            ovf  <= 1'b0;
        end else begin
            pend <= pend_next;
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_prio_enc_queue.sv
// Self-checking bench for prio_enc_queue: reset, truth table, simultaneous capture,
// overflow, preemption and (when PRIO_ENC_RR_EN is defined) round-robin ordering.
module tb_prio_enc_queue;
    localparam int N = 8;
    localparam int W = $clog2(N);

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic         out_ready;
    logic         clr_ovf;
    logic         out_valid;
    logic [W-1:0] out_code;
    logic [N-1:0] pending;
    logic         ovf;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_code;
    int checks;
    int errors;

    prio_enc_queue #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_ready (out_ready),
        .clr_ovf   (clr_ovf),
        .out_valid (out_valid),
        .out_code  (out_code),
        .pending   (pending),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n     = 1'b0;
        req       = '0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        req       = '0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        tick();
        tick();
        checks++;
        if (pending !== '0 || out_valid !== 1'b0 || out_code !== '0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset: pending=%h valid=%b code=%0d ovf=%b, required 00 0 0 0",
                     pending, out_valid, out_code, ovf);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_truth_table;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL tt_idle%0d: valid=%b, required 0", i, out_valid);
            end
            req = N'(1) << i;
            exp_q.push_back(W'(i));
            tick();
            req = '0;
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL tt_valid%0d: valid=%b, required 1", i, out_valid);
            end
            exp_code = exp_q.pop_front();
            checks++;
            if (out_code !== exp_code) begin
                errors++;
                $display("FAIL tt_code%0d: code=%0d, required %0d", i, out_code, exp_code);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL tt_drain: valid=%b, required 0", out_valid);
        end
        // Build up pending state and overflow, then reset asynchronously between edges.
        out_ready = 1'b0;
        req = 8'h0C;
        tick();
        tick();
        req = '0;
        checks++;
        if (pending !== 8'h0C || ovf !== 1'b1) begin
            errors++;
            $display("FAIL tt_pre_rst: pending=%h ovf=%b, required 0c 1", pending, ovf);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pending !== '0 || out_valid !== 1'b0 || out_code !== '0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL async_rst: pending=%h valid=%b code=%0d ovf=%b, required 00 0 0 0",
                     pending, out_valid, out_code, ovf);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_simultaneous;
        logic [N-1:0] exp_pend[4];
        exp_pend = '{8'h26, 8'h06, 8'h02, 8'h00};
        do_reset();
        req = 8'hA6;
        tick();
        req = '0;
        checks++;
        if (pending !== 8'hA6) begin
            errors++;
            $display("FAIL sim_capture: pending=%h, required a6", pending);
        end
        exp_q.push_back(W'(7));
        exp_q.push_back(W'(5));
        exp_q.push_back(W'(2));
        exp_q.push_back(W'(1));
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_code = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_code !== exp_code) begin
                errors++;
                $display("FAIL sim_pop%0d: valid=%b code=%0d, required 1 %0d",
                         k, out_valid, out_code, exp_code);
            end
            tick();
            checks++;
            if (pending !== exp_pend[k]) begin
                errors++;
                $display("FAIL sim_pend%0d: pending=%h, required %h", k, pending, exp_pend[k]);
            end
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sim_empty: valid=%b, required 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow;
        do_reset();
        req = 8'h08;
        tick();
        req = '0;
        tick();
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_first: ovf=%b, required 0", ovf);
        end
        req = 8'h08;
        tick();
        req = '0;
        checks++;
        if (ovf !== 1'b1 || pending !== 8'h08) begin
            errors++;
            $display("FAIL ovf_set: ovf=%b pending=%h, required 1 08", ovf, pending);
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b, required 0", ovf);
        end
        // Set and clear together: set wins.
        req = 8'h08;
        clr_ovf = 1'b1;
        tick();
        req = '0;
        clr_ovf = 1'b0;
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins: ovf=%b, required 1", ovf);
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        // Request on the line being popped stays pending and is not an overflow.
        exp_q.push_back(W'(3));
        req = 8'h08;
        out_ready = 1'b1;
        exp_code = exp_q.pop_front();
        checks++;
        if (out_code !== exp_code) begin
            errors++;
            $display("FAIL ovf_pop_code: code=%0d, required %0d", out_code, exp_code);
        end
        tick();
        req = '0;
        checks++;
        if (pending !== 8'h08 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_pop_req: pending=%h ovf=%b, required 08 0", pending, ovf);
        end
        tick();
        out_ready = 1'b0;
        checks++;
        if (pending !== '0) begin
            errors++;
            $display("FAIL ovf_drain: pending=%h, required 00", pending);
        end
    endtask

    task automatic test_preempt;
        do_reset();
        req = 8'h04;
        tick();
        req = '0;
        tick();
        checks++;
        if (out_code !== W'(2)) begin
            errors++;
            $display("FAIL pre_hold: code=%0d, required 2", out_code);
        end
        req = 8'h40;
        tick();
        req = '0;
        exp_q.push_back(W'(6));
        exp_q.push_back(W'(2));
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_code = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_code !== exp_code) begin
                errors++;
                $display("FAIL pre_pop%0d: valid=%b code=%0d, required 1 %0d",
                         k, out_valid, out_code, exp_code);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL pre_empty: valid=%b, required 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

`ifdef PRIO_ENC_RR_EN
    task automatic test_round_robin;
        do_reset();
        req = '1;
        out_ready = 1'b1;
        tick();
        for (int k = 0; k < 2 * N; k++) exp_q.push_back(W'(N - 1 - (k % N)));
        for (int k = 0; k < 2 * N; k++) begin
            exp_code = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_code !== exp_code) begin
                errors++;
                $display("FAIL rr_pop%0d: valid=%b code=%0d, required 1 %0d",
                         k, out_valid, out_code, exp_code);
            end
            tick();
            if (k == 0) begin
                checks++;
                if (ovf !== 1'b1) begin
                    errors++;
                    $display("FAIL rr_ovf: ovf=%b, required 1", ovf);
                end
            end
        end
        req = '0;
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_truth_table();
        test_simultaneous();
        test_overflow();
        test_preempt();
`ifdef PRIO_ENC_RR_EN
        test_round_robin();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
